game_timer: RTL and testbench

GAME_TIMER -- requirements
Module: game_timer

---
 rtl/game_timer.sv | 147 ++++++++++++++
 tb/tb_game_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// Module  : game_timer
// Brief   : BCD stopwatch (MM:SS.hh) with start/stop/clear control and
//           saturation at 99:59.99; feeds the display rotator.
// Rev     : 1.0
// ============================================================================
module game_timer #(
    parameter int TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] digit5,
    output logic [3:0] digit6,
    output logic [3:0] digit7,
    output logic       running,
    output logic       saturated
);

    localparam int              c_PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0] c_PRE_ONE = c_PW'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_STOPPED = 2'd2;
    localparam logic [1:0] S_SAT     = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_PW-1:0] r_pre;
    logic            r_running;
    logic            r_saturated;
    logic [3:0]      r_h0, r_h1, r_s0, r_s1, r_m0, r_m1;
    logic [3:0]      w_h0, w_h1, w_s0, w_s1, w_m0, w_m1;
    logic            w_tick;
    logic            w_at_max;

    assign w_tick   = (r_state == S_RUNNING) && (r_pre == c_PRE_MAX);
    assign w_at_max = (r_m1 == 4'd9) && (r_m0 == 4'd9) && (r_s1 == 4'd5) &&
                      (r_s0 == 4'd9) && (r_h1 == 4'd9) && (r_h0 == 4'd9);

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_STOPPED: if (start) w_state_nxt = S_RUNNING;
                S_RUNNING: begin
                    // A tick coinciding with stop still lands before pausing.
                    if (w_tick && w_at_max) w_state_nxt = S_SAT;
                    else if (stop)          w_state_nxt = S_STOPPED;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Ripple-carry BCD increment resolved entirely within one cycle.
    always_comb begin
        w_h0 = r_h0;
        w_h1 = r_h1;
        w_s0 = r_s0;
        w_s1 = r_s1;
        w_m0 = r_m0;
        w_m1 = r_m1;
        if (r_h0 != 4'd9) begin
            w_h0 = r_h0 + 4'd1;
        end else begin
            w_h0 = 4'd0;
            if (r_h1 != 4'd9) begin
                w_h1 = r_h1 + 4'd1;
            end else begin
                w_h1 = 4'd0;
                if (r_s0 != 4'd9) begin
                    w_s0 = r_s0 + 4'd1;
                end else begin
                    w_s0 = 4'd0;
                    if (r_s1 != 4'd5) begin
                        w_s1 = r_s1 + 4'd1;
                    end else begin
                        w_s1 = 4'd0;
                        if (r_m0 != 4'd9) begin
                            w_m0 = r_m0 + 4'd1;
                        end else begin
                            w_m0 = 4'd0;
                            w_m1 = r_m1 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_running   <= 1'b0;
            r_saturated <= 1'b0;
            r_h0        <= 4'd0;
            r_h1        <= 4'd0;
            r_s0        <= 4'd0;
            r_s1        <= 4'd0;
            r_m0        <= 4'd0;
            r_m1        <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_running   <= (w_state_nxt == S_RUNNING);
            r_saturated <= (w_state_nxt == S_SAT);
            // Prescaler holds outside RUNNING so a resume keeps the partial hundredth.
            if (r_state == S_RUNNING) begin
                r_pre <= w_tick ? '0 : r_pre + c_PRE_ONE;
            end
            if (w_tick && !w_at_max) begin
                r_h0 <= w_h0;
                r_h1 <= w_h1;
                r_s0 <= w_s0;
                r_s1 <= w_s1;
                r_m0 <= w_m0;
                r_m1 <= w_m1;
            end
        end
    end

    assign digit0    = r_h0;
    assign digit1    = r_h1;
    assign digit2    = r_s0;
    assign digit3    = r_s1;
    assign digit4    = r_s0;
    assign digit5    = r_s1;
    assign digit6    = r_m0;
    assign digit7    = r_m1;
    assign running   = r_running;
    assign saturated = r_saturated;

endmodule
`default_nettype wire

// File: tb/tb_game_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_timer
// Brief   : Randomized + directed bench for game_timer against a time-in-
//           hundredths reference model.
// Rev     : 1.0
// ============================================================================
module tb_game_timer;

    localparam int c_TD      = 4;
    localparam int c_MAX_T   = 599999;
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_STOP    = 2;
    localparam int M_SAT     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;
    logic       running, saturated;
    logic [3:0] f_h0, f_h1, f_s0, f_s1, f_m0, f_m1;

    int n_err = 0;
    int n_chk = 0;
    int m_t = 0;
    int m_pre = 0;
    int m_mode = M_IDLE;

    game_timer #(.TICK_DIV(c_TD)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .digit4(digit4), .digit5(digit5), .digit6(digit6), .digit7(digit7),
        .running(running), .saturated(saturated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] disp_of(input int t);
        int h, s, m;
        h = t % 100;
        s = (t / 100) % 60;
        m = t / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    // Reference behaviour: elapsed hundredths as one integer.
    task automatic model_step();
        if (rst || clear) begin
            m_t = 0; m_pre = 0; m_mode = M_IDLE;
        end else if (m_mode == M_RUN) begin
            if (m_pre == c_TD - 1) begin
                m_pre = 0;
                if (m_t == c_MAX_T) m_mode = M_SAT;
                else                m_t = m_t + 1;
            end else begin
                m_pre = m_pre + 1;
            end
            if (m_mode == M_RUN && stop) m_mode = M_STOP;
        end else if ((m_mode == M_IDLE || m_mode == M_STOP) && start) begin
            m_mode = M_RUN;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse(input logic s, input logic p, input logic c, input logic r);
        start = s; stop = p; clear = c; rst = r;
        cyc();
        start = 1'b0; stop = 1'b0; clear = 1'b0; rst = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".digits"}, {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0},
              disp_of(m_t));
        check({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
        check({tag, ".saturated"}, 32'(saturated), 32'(m_mode == M_SAT));
    endtask

    // Loads a time into the digit registers while the timer is paused.
    task automatic force_time(input int t);
        logic [31:0] d;
        d = disp_of(t);
        f_h0 = d[3:0];  f_h1 = d[7:4];  f_s0 = d[11:8];
        f_s1 = d[15:12]; f_m0 = d[27:24]; f_m1 = d[31:28];
        force dut.r_h0 = f_h0;
        force dut.r_h1 = f_h1;
        force dut.r_s0 = f_s0;
        force dut.r_s1 = f_s1;
        force dut.r_m0 = f_m0;
        force dut.r_m1 = f_m1;
        #1;
        release dut.r_h0;
        release dut.r_h1;
        release dut.r_s0;
        release dut.r_s1;
        release dut.r_m0;
        release dut.r_m1;
        m_t = t;
    endtask

    initial begin
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        check_all("reset");
        check("reset.zero", {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0}, 32'h0);

        // One second of running.
        pulse(1, 0, 0, 0);
        idle(400);
        check_all("one_sec");
        check("one_sec.const", {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0},
              32'h0001_0100);
        check("one_sec.running", 32'(running), 32'd1);

        // Pause keeps the partial hundredth.
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        idle(6);
        pulse(0, 1, 0, 0);
        idle(20);
        check_all("paused");
        pulse(1, 0, 0, 0);
        idle(2);
        check("resume.const", {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0},
              32'h0000_0002);
        check_all("resume");

        // Seconds carry into minutes.
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        force_time(5999);
        pulse(1, 0, 0, 0);
        idle(3);
        check("minute.const", {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0},
              32'h0100_0000);
        check_all("minute");

        // Saturation at 99:59.99.
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        force_time(c_MAX_T - 1);
        pulse(1, 0, 0, 0);
        idle(8);
        check("sat.const", {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0},
              32'h9959_5999);
        check("sat.flag", 32'(saturated), 32'd1);
        check("sat.running", 32'(running), 32'd0);
        pulse(1, 0, 0, 0);
        idle(8);
        check_all("sat_hold");

        // Clear beats start while running.
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        idle(37);
        pulse(1, 0, 1, 0);
        check("clear.const", {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0}, 32'h0);
        check("clear.running", 32'(running), 32'd0);
        check_all("clear");

        // Reset mid-run at prescaler 2.
        pulse(1, 0, 0, 0);
        idle(50);
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        idle(2);
        pulse(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            check("rst_mid.digits", {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0},
                  32'h0);
            check("rst_mid.running", 32'(running), 32'd0);
            cyc();
        end

        // Random control traffic, checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            clear = ($urandom_range(0, 63) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            cyc();
            check_all("random");
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0; rst = 1'b0;

        // Random pulses around the saturation point.
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        force_time(c_MAX_T - 3);
        for (int i = 0; i < 200; i++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 99) == 0);
            cyc();
            check_all("random_sat");
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
